cpu_ctrl_exec: RTL and testbench

- Multi-cycle control and execute slice of the MiniComputer CPU.
- Contains three parts:
  - the main controller FSM, which sequences fetch, decode, execute, memory and writeback and emits register load enables and bus controls;
  - the 32-bit combinational ALU;
  - the data-memory address adder.
- Sits between the instruction/register/data paths and the shared data-memory bus; the PC-select and ALU-op decoder lives outside this block.

---
 rtl/cpu_pkg.sv | 83 ++++++++
 rtl/cpu_alu.sv | 35 +++
 rtl/cpu_ctrl_exec.sv | 144 ++++++++++++++
 tb/tb_cpu_ctrl_exec.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MiniComputer control/execute slice.
package cpu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned SALU_W  = 5;
    localparam int unsigned STATE_W = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned SZ_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 5'd0,
        S_FETCH  = 5'd1,
        S_DECODE = 5'd2,
        S_EXEC   = 5'd3,
        S_WB     = 5'd4,
        S_MREQ   = 5'd5,
        S_MRD    = 5'd6,
        S_LWB    = 5'd7,
        S_MWR    = 5'd8,
        S_BR     = 5'd9,
        S_JMP    = 5'd10
    } state_t;

    localparam logic [OPC_W-1:0] OP_ALU_MAX = 6'h1F;
    localparam logic [OPC_W-1:0] OP_LB      = 6'h20;
    localparam logic [OPC_W-1:0] OP_LW      = 6'h21;
    localparam logic [OPC_W-1:0] OP_LH      = 6'h22;
    localparam logic [OPC_W-1:0] OP_SB      = 6'h24;
    localparam logic [OPC_W-1:0] OP_SW      = 6'h25;
    localparam logic [OPC_W-1:0] OP_SH      = 6'h26;
    localparam logic [OPC_W-1:0] OP_BR_LO   = 6'h28;
    localparam logic [OPC_W-1:0] OP_BR_HI   = 6'h2F;
    localparam logic [OPC_W-1:0] OP_J       = 6'h30;
    localparam logic [OPC_W-1:0] OP_JAL     = 6'h31;
    localparam logic [OPC_W-1:0] OP_HALT    = 6'h3F;
    localparam logic [OPC_W-1:0] OP_MEM_LO  = 6'h20;

    localparam logic [SALU_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [SALU_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [SALU_W-1:0] ALU_AND  = 5'd2;
    localparam logic [SALU_W-1:0] ALU_OR   = 5'd3;
    localparam logic [SALU_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [SALU_W-1:0] ALU_NOR  = 5'd5;
    localparam logic [SALU_W-1:0] ALU_SLL  = 5'd6;
    localparam logic [SALU_W-1:0] ALU_SRL  = 5'd7;
    localparam logic [SALU_W-1:0] ALU_SRA  = 5'd8;
    localparam logic [SALU_W-1:0] ALU_SLT  = 5'd9;
    localparam logic [SALU_W-1:0] ALU_SLTU = 5'd10;
    localparam logic [SALU_W-1:0] ALU_MUL  = 5'd11;
    localparam logic [SALU_W-1:0] ALU_PASS = 5'd12;

    localparam logic [SZ_W-1:0] SZ_NONE = 2'd0;
    localparam logic [SZ_W-1:0] SZ_BYTE = 2'd1;
    localparam logic [SZ_W-1:0] SZ_HALF = 2'd2;
    localparam logic [SZ_W-1:0] SZ_WORD = 2'd3;

    typedef enum logic [2:0] {
        C_ALU, C_LOAD, C_STORE, C_BR, C_JMP, C_HALT, C_NOP
    } opclass_t;

    // Classify an opcode into the sequencing class used by DECODE.
    function automatic opclass_t op_class(input logic [OPC_W-1:0] op);
        if (op <= OP_ALU_MAX)                      return C_ALU;
        if (op == OP_LB || op == OP_LW || op == OP_LH) return C_LOAD;
        if (op == OP_SB || op == OP_SW || op == OP_SH) return C_STORE;
        if (op >= OP_BR_LO && op <= OP_BR_HI)      return C_BR;
        if (op == OP_J || op == OP_JAL)            return C_JMP;
        if (op == OP_HALT)                         return C_HALT;
        return C_NOP;
    endfunction

    // Access size of a load/store opcode; none for anything else.
    function automatic logic [SZ_W-1:0] op_size(input logic [OPC_W-1:0] op);
        case (op)
            OP_LB, OP_SB: return SZ_BYTE;
            OP_LH, OP_SH: return SZ_HALF;
            OP_LW, OP_SW: return SZ_WORD;
            default:      return SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// 32-bit combinational ALU, wrap-around arithmetic, no flags.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SALU_W-1:0] salu,
    output logic [DATA_W-1:0] res
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // Operation select; undefined select codes yield zero.
    always_comb begin
        res = '0;
        case (salu)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLL:  res = a << shamt;
            ALU_SRL:  res = a >> shamt;
            ALU_SRA:  res = DATA_W'($signed(a) >>> shamt);
            ALU_SLT:  res = DATA_W'($signed(a) < $signed(b));
            ALU_SLTU: res = DATA_W'(a < b);
            ALU_MUL:  res = a * b;
            ALU_PASS: res = b;
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_exec.sv
// Multi-cycle controller FSM, ALU and data-memory address adder.
module cpu_ctrl_exec
    import cpu_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                Start,
    input  logic                grt,
    input  logic [DATA_W-1:0]   alu_a,
    input  logic [DATA_W-1:0]   alu_b,
    input  logic [SALU_W-1:0]   salu,
    input  logic [DATA_W-1:0]   addr_base,
    input  logic [IMM_W-1:0]    imm16,
    output logic [DATA_W-1:0]   alu_res,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [STATE_W-1:0]  ps,
    output logic [SZ_W-1:0]     WDM,
    output logic [SZ_W-1:0]     RDM,
    output logic [SZ_W-1:0]     RIM,
    output logic                Ready,
    output logic                LdIR,
    output logic                LdA,
    output logic                LdB,
    output logic                LdALU,
    output logic                LdMDR,
    output logic                WRF,
    output logic                CPC,
    output logic                SWA,
    output logic                sssb,
    output logic                IFF,
    output logic                req,
    output logic                cs
);

    state_t   state, state_nx;
    opclass_t cls;

    assign cls      = op_class(opcode);
    assign ps       = state;
    assign sssb     = (opcode >= OP_MEM_LO);
    assign mem_addr = addr_base + {{(DATA_W-IMM_W){1'b0}}, imm16};

    cpu_alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .salu (salu),
        .res  (alu_res)
    );

    // State register; reset drops straight back to IDLE from any state.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state and Moore control outputs.
    always_comb begin
        state_nx = state;
        WDM   = SZ_NONE;
        RDM   = SZ_NONE;
        RIM   = SZ_NONE;
        Ready = 1'b0;
        LdIR  = 1'b0;
        LdA   = 1'b0;
        LdB   = 1'b0;
        LdALU = 1'b0;
        LdMDR = 1'b0;
        WRF   = 1'b0;
        CPC   = 1'b0;
        SWA   = 1'b0;
        IFF   = 1'b0;
        req   = 1'b0;
        cs    = 1'b0;
        case (state)
            S_IDLE: begin
                Ready = 1'b1;
                if (Start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                RIM      = SZ_WORD;
                LdIR     = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                LdA = 1'b1;
                LdB = 1'b1;
                case (cls)
                    C_ALU:   state_nx = S_EXEC;
                    C_LOAD,
                    C_STORE: state_nx = S_MREQ;
                    C_BR:    state_nx = S_BR;
                    C_JMP:   state_nx = S_JMP;
                    C_HALT:  state_nx = S_IDLE;
                    default: begin
                        CPC      = 1'b1;
                        state_nx = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                LdALU    = 1'b1;
                state_nx = S_WB;
            end
            S_WB, S_LWB: begin
                WRF      = 1'b1;
                CPC      = 1'b1;
                state_nx = S_FETCH;
            end
            S_MREQ: begin
                req = 1'b1;
                if (grt) state_nx = (cls == C_STORE) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                req      = 1'b1;
                cs       = 1'b1;
                RDM      = op_size(opcode);
                LdMDR    = 1'b1;
                state_nx = S_LWB;
            end
            S_MWR: begin
                req      = 1'b1;
                cs       = 1'b1;
                WDM      = op_size(opcode);
                CPC      = 1'b1;
                state_nx = S_FETCH;
            end
            S_BR: begin
                IFF      = 1'b1;
                CPC      = 1'b1;
                state_nx = S_FETCH;
            end
            S_JMP: begin
                IFF      = 1'b1;
                CPC      = 1'b1;
                WRF      = (opcode == OP_JAL);
                SWA      = (opcode == OP_JAL);
                state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_exec.sv
// Directed self-checking bench for cpu_ctrl_exec.
module tb_cpu_ctrl_exec;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic        Start = 1'b0;
    logic        grt = 1'b0;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [4:0]  salu = '0;
    logic [31:0] addr_base = '0;
    logic [15:0] imm16 = '0;
    logic [31:0] alu_res, mem_addr;
    logic [4:0]  ps;
    logic [1:0]  WDM, RDM, RIM;
    logic Ready, LdIR, LdA, LdB, LdALU, LdMDR, WRF, CPC, SWA, sssb, IFF, req, cs;

    int checks = 0;
    int errors = 0;

    // Control outputs packed for compact comparison.
    logic [17:0] ctl;
    assign ctl = {WDM, RDM, RIM, Ready, LdIR, LdA, LdB, LdALU, LdMDR, WRF, CPC, SWA, IFF, req, cs};

    localparam logic [17:0] K_CS    = 18'h00001;
    localparam logic [17:0] K_REQ   = 18'h00002;
    localparam logic [17:0] K_IFF   = 18'h00004;
    localparam logic [17:0] K_SWA   = 18'h00008;
    localparam logic [17:0] K_CPC   = 18'h00010;
    localparam logic [17:0] K_WRF   = 18'h00020;
    localparam logic [17:0] K_LDMDR = 18'h00040;
    localparam logic [17:0] K_LDALU = 18'h00080;
    localparam logic [17:0] K_LDB   = 18'h00100;
    localparam logic [17:0] K_LDA   = 18'h00200;
    localparam logic [17:0] K_LDIR  = 18'h00400;
    localparam logic [17:0] K_READY = 18'h00800;
    localparam logic [17:0] K_RIM3  = 18'h03000;
    localparam logic [17:0] K_RDM1  = 18'h04000;
    localparam logic [17:0] K_RDM3  = 18'h0C000;
    localparam logic [17:0] K_WDM1  = 18'h10000;
    localparam logic [17:0] K_WDM3  = 18'h30000;

    cpu_ctrl_exec dut (
        .Clk(Clk), .Rst(Rst), .opcode(opcode), .Start(Start), .grt(grt),
        .alu_a(alu_a), .alu_b(alu_b), .salu(salu), .addr_base(addr_base),
        .imm16(imm16), .alu_res(alu_res), .mem_addr(mem_addr), .ps(ps),
        .WDM(WDM), .RDM(RDM), .RIM(RIM), .Ready(Ready), .LdIR(LdIR),
        .LdA(LdA), .LdB(LdB), .LdALU(LdALU), .LdMDR(LdMDR), .WRF(WRF),
        .CPC(CPC), .SWA(SWA), .sssb(sssb), .IFF(IFF), .req(req), .cs(cs)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_st(input string tag, input logic [4:0] eps, input logic [17:0] ectl);
        chk({tag, " ps"}, 32'(ps), 32'(eps));
        chk({tag, " ctl"}, 32'(ctl), 32'(ectl));
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv);
        salu = op; alu_a = a; alu_b = b;
        #1;
        chk(tag, alu_res, expv);
    endtask

    initial begin
        // Reset state
        #12;
        chk_st("reset", 5'd0, K_READY);
        @(negedge Clk); Rst = 1'b1;
        step(); chk_st("idle hold", 5'd0, K_READY);

        // Word load with immediate grant
        opcode = 6'h21; grt = 1'b1; Start = 1'b1;
        step(); chk_st("lw fetch", 5'd1, K_RIM3 | K_LDIR);
        chk("lw sssb", 32'(sssb), 32'd1);
        Start = 1'b0;
        step(); chk_st("lw decode", 5'd2, K_LDA | K_LDB);
        step(); chk_st("lw mreq", 5'd5, K_REQ);
        step(); chk_st("lw mrd", 5'd6, K_REQ | K_CS | K_RDM3 | K_LDMDR);
        chk("lw mrd sssb", 32'(sssb), 32'd1);
        step(); chk_st("lw lwb", 5'd7, K_WRF | K_CPC);
        step(); chk_st("lw refetch", 5'd1, K_RIM3 | K_LDIR);

        // Load with grant held off three cycles; grant drops during MRD
        grt = 1'b0;
        step(); chk_st("gw decode", 5'd2, K_LDA | K_LDB);
        step(); chk_st("gw wait1", 5'd5, K_REQ);
        step(); chk_st("gw wait2", 5'd5, K_REQ);
        step(); chk_st("gw wait3", 5'd5, K_REQ);
        grt = 1'b1;
        step(); chk_st("gw mrd", 5'd6, K_REQ | K_CS | K_RDM3 | K_LDMDR);
        grt = 1'b0;
        step(); chk_st("gw lwb", 5'd7, K_WRF | K_CPC);
        step(); chk_st("gw fetch", 5'd1, K_RIM3 | K_LDIR);

        // Word store then byte store
        opcode = 6'h25; grt = 1'b1;
        step(); chk_st("sw decode", 5'd2, K_LDA | K_LDB);
        step(); chk_st("sw mreq", 5'd5, K_REQ);
        step(); chk_st("sw mwr", 5'd8, K_REQ | K_CS | K_WDM3 | K_CPC);
        step(); chk_st("sw fetch", 5'd1, K_RIM3 | K_LDIR);
        opcode = 6'h24;
        step(); step();
        step(); chk_st("sb mwr", 5'd8, K_REQ | K_CS | K_WDM1 | K_CPC);
        step(); chk_st("sb fetch", 5'd1, K_RIM3 | K_LDIR);

        // ALU instruction; Start held high must be ignored
        opcode = 6'h05; Start = 1'b1;
        #1 chk("alu sssb", 32'(sssb), 32'd0);
        step(); chk_st("alu decode", 5'd2, K_LDA | K_LDB);
        step(); chk_st("alu exec", 5'd3, K_LDALU);
        step(); chk_st("alu wb", 5'd4, K_WRF | K_CPC);
        step(); chk_st("alu fetch", 5'd1, K_RIM3 | K_LDIR);

        // Branch
        opcode = 6'h2A;
        step(); step(); chk_st("br", 5'd9, K_IFF | K_CPC);
        step(); chk_st("br fetch", 5'd1, K_RIM3 | K_LDIR);
        Start = 1'b0;

        // Jump-and-link and plain jump
        opcode = 6'h31;
        step(); step(); chk_st("jal", 5'd10, K_IFF | K_CPC | K_WRF | K_SWA);
        step(); chk_st("jal fetch", 5'd1, K_RIM3 | K_LDIR);
        opcode = 6'h30;
        step(); step(); chk_st("j", 5'd10, K_IFF | K_CPC);
        step();

        // NOP advances PC from DECODE
        opcode = 6'h3A;
        step(); chk_st("nop decode", 5'd2, K_LDA | K_LDB | K_CPC);
        step(); chk_st("nop fetch", 5'd1, K_RIM3 | K_LDIR);

        // Halt returns to IDLE without CPC
        opcode = 6'h3F;
        step(); chk_st("halt decode", 5'd2, K_LDA | K_LDB);
        step(); chk_st("halt idle", 5'd0, K_READY);
        step(); chk_st("halt stay", 5'd0, K_READY);

        // Async reset during a byte load's MRD
        opcode = 6'h20; grt = 1'b1; Start = 1'b1;
        step(); Start = 1'b0;
        step(); step();
        step(); chk_st("lb mrd", 5'd6, K_REQ | K_CS | K_RDM1 | K_LDMDR);
        #2 Rst = 1'b0;
        #1 chk_st("async rst", 5'd0, K_READY);
        @(negedge Clk); Rst = 1'b1;
        step(); chk_st("post rst", 5'd0, K_READY);

        // ALU datapath
        alu("add wrap", 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu("sub wrap", 5'd1, 32'h0, 32'h1, 32'hFFFF_FFFF);
        alu("and", 5'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        alu("or",  5'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
        alu("xor", 5'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        alu("nor", 5'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000);
        alu("sll", 5'd6, 32'h1, 32'd31, 32'h8000_0000);
        alu("srl", 5'd7, 32'h8000_0000, 32'h24, 32'h0800_0000);
        alu("sra", 5'd8, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu("slt", 5'd9, 32'hFFFF_FFFF, 32'h1, 32'h1);
        alu("sltu", 5'd10, 32'hFFFF_FFFF, 32'h1, 32'h0);
        alu("mul", 5'd11, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F);
        alu("pass", 5'd12, 32'h1234_5678, 32'hCAFE_BABE, 32'hCAFE_BABE);
        alu("undef", 5'd20, 32'h1234_5678, 32'hCAFE_BABE, 32'h0);

        // Address adder
        addr_base = 32'h8; imm16 = 16'hFFFF;
        #1 chk("addr zext", mem_addr, 32'h0001_0007);
        addr_base = 32'hFFFF_FFFF; imm16 = 16'h0001;
        #1 chk("addr wrap", mem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
